// File: rtl/shared_pipe_scheduler.sv
// Round-robin scheduler for one fixed-latency pipelined resource shared by NUM_REQ requesters.
// A {valid, tag} token follows each issue through the pipe so results return to their owners.
module shared_pipe_scheduler #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned PIPE_LATENCY = 3,
  localparam int unsigned SelW        = $clog2(NUM_REQ),
  localparam int unsigned CntW        = $clog2(PIPE_LATENCY + 1)
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               hold_i,
  input  logic               flush_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               issue_valid_o,
  output logic [SelW-1:0]    issue_sel_o,
  output logic               pipe_en_o,
  output logic [NUM_REQ-1:0] res_valid_o,
  output logic [SelW-1:0]    res_sel_o,
  output logic               busy_o
);

  localparam int unsigned Last = PIPE_LATENCY - 1;

  logic [SelW-1:0]         ptr_q, ptr_d;
  logic [PIPE_LATENCY-1:0] vld_q, vld_d;
  logic [SelW-1:0]         tag_q [PIPE_LATENCY];
  logic [SelW-1:0]         tag_d [PIPE_LATENCY];
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    arb_en, found, retire, out_en;
  int unsigned             arb_idx;

  assign arb_en = reset_ni & ~hold_i & ~flush_i;

  // Scan from ptr+1 upward with wrap; first set request wins.
  always_comb begin
    gnt_o       = '0;
    issue_sel_o = '0;
    found       = 1'b0;
    arb_idx     = 0;
    if (arb_en) begin
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
        arb_idx = (32'(ptr_q) + i) % NUM_REQ;
        if (!found && req_i[arb_idx]) begin
          found          = 1'b1;
          gnt_o[arb_idx] = 1'b1;
          issue_sel_o    = SelW'(arb_idx);
        end
      end
    end
  end

  assign issue_valid_o = found;
  assign ptr_d         = found ? issue_sel_o : ptr_q;
  assign pipe_en_o     = ~hold_i;

  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    if (flush_i) begin
      vld_d = '0;
    end else if (!hold_i) begin
      vld_d[0] = issue_valid_o;
      tag_d[0] = issue_sel_o;
      for (int k = 1; k < int'(PIPE_LATENCY); k++) begin
        vld_d[k] = vld_q[k-1];
        tag_d[k] = tag_q[k-1];
      end
    end
  end

  assign retire = vld_q[Last] & ~hold_i;

  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else if (issue_valid_o && !retire) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!issue_valid_o && retire) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      ptr_q <= SelW'(NUM_REQ - 1);
      vld_q <= '0;
      cnt_q <= '0;
      for (int k = 0; k < int'(PIPE_LATENCY); k++) tag_q[k] <= '0;
    end else begin
      ptr_q <= ptr_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      for (int k = 0; k < int'(PIPE_LATENCY); k++) tag_q[k] <= tag_d[k];
    end
  end

  // A held last stage is shown only once hold drops; flushed or reset tokens never strobe.
  assign out_en = vld_q[Last] & ~hold_i & ~flush_i & reset_ni;

  always_comb begin
    res_valid_o = '0;
    res_sel_o   = '0;
    if (out_en) begin
      res_valid_o[tag_q[Last]] = 1'b1;
      res_sel_o                = tag_q[Last];
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule
